// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: rx synchronizer, bit-framing FSM and a
// small receive FIFO popped one character per bus read.
module uart_rx_port #(
  parameter int CLKS_PER_BIT = 173,
  parameter int DEPTH        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  input  logic        uart_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  typedef struct packed {
    logic [20:0] zero;
    logic        ferr;
    logic        overrun;
    logic        nonempty;
    logic [7:0]  data;
  } rx_word_t;

  logic unused_ok;
  assign unused_ok = ^{uart_instr, uart_addr, uart_wdata};

  // ---------------- synchronizer + edge detect ----------------
  logic rx_meta, rx_s, rx_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  logic fall;
  assign fall = rx_prev & ~rx_s;

  // ---------------- framing FSM ----------------
  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          cnt_clr, idx_clr, bit_smp, stop_ok, stop_bad;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (fall) state_nx = START;
      START: if (cnt == CNT_HALF) state_nx = rx_s ? IDLE : DATA;
      DATA:  if (cnt == CNT_LAST && idx == 3'd7) state_nx = STOP;
      STOP:  if (cnt == CNT_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    idx_clr  = 1'b0;
    bit_smp  = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE:  cnt_clr = 1'b1;
      START: if (cnt == CNT_HALF) begin
        cnt_clr = 1'b1;
        idx_clr = 1'b1;
      end
      DATA:  if (cnt == CNT_LAST) begin
        cnt_clr = 1'b1;
        bit_smp = 1'b1;
      end
      STOP:  if (cnt == CNT_LAST) begin
        cnt_clr  = 1'b1;
        stop_ok  = rx_s;
        stop_bad = ~rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (idx_clr) idx <= '0;
      else if (bit_smp) begin
        shift[idx] <= rx_s;
        idx        <= idx + 1'b1;
      end
    end
  end

  // ---------------- receive FIFO ----------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          rd_req, nonempty, full, pop, push, ovr_set;
  logic [7:0]    head;

  assign rd_req   = uart_valid && (uart_wstrb == 4'h0);
  assign nonempty = (count != '0);
  assign full     = (count == CNT_FULL);
  assign pop      = rd_req && nonempty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign push     = stop_ok && (!full || pop);
  assign ovr_set  = stop_ok && full && !pop;
  assign head     = nonempty ? mem[rptr] : 8'h00;

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= shift;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- status flags + bus response ----------------
  logic     ferr, overrun;
  rx_word_t rd_word;

  always_comb begin
    rd_word          = '0;
    rd_word.ferr     = ferr;
    rd_word.overrun  = overrun;
    rd_word.nonempty = nonempty;
    rd_word.data     = head;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ferr       <= 1'b0;
      overrun    <= 1'b0;
      uart_ready <= 1'b0;
      uart_rdata <= '0;
    end else begin
      // A flag raised in the same cycle as a clearing read survives it.
      ferr       <= stop_bad | (ferr & ~rd_req);
      overrun    <= ovr_set  | (overrun & ~rd_req);
      uart_ready <= uart_valid;
      if (rd_req) uart_rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port: serial frames in, bus reads checked
// against a queue of expected read words.
module tb_uart_rx_port;

  localparam int CPB = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        uart_valid = 1'b0;
  logic        uart_instr = 1'b0;
  logic [31:0] uart_addr = 32'h0100_0004;
  logic [31:0] uart_wdata = 32'h0;
  logic [3:0]  uart_wstrb = 4'h0;
  logic [31:0] uart_rdata;
  logic        uart_ready;
  logic        uart_rx = 1'b1;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  uart_rx_port #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .uart_valid(uart_valid), .uart_instr(uart_instr),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb),
    .uart_rdata(uart_rdata), .uart_ready(uart_ready), .uart_rx(uart_rx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Call at a negedge; the frame ends at the negedge 10*CPB later.
  task automatic send(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
  endtask

  // Call at a negedge; checks the one-cycle response and the ready pulse width.
  task automatic rd(input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    uart_valid = 1'b1;
    uart_wstrb = 4'h0;
    @(negedge clock);
    uart_valid = 1'b0;
    e = exp_q.pop_front();
    check("rd_ready", {31'b0, uart_ready}, 32'h1);
    check("rd_data", uart_rdata, e);
    @(negedge clock);
    check("rd_ready_low", {31'b0, uart_ready}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] held);
    uart_valid = 1'b1;
    uart_wstrb = 4'hF;
    uart_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    uart_valid = 1'b0;
    uart_wstrb = 4'h0;
    check("wr_ready", {31'b0, uart_ready}, 32'h1);
    check("wr_hold", uart_rdata, held);
    @(negedge clock);
    check("wr_ready_low", {31'b0, uart_ready}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_ready", {31'b0, uart_ready}, 32'h0);
    check("rst_rdata", uart_rdata, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // single byte, plus a write that must not disturb anything
    send(8'h55, 1'b1);
    repeat (4) @(negedge clock);
    rd(32'h155);
    wr(32'h155);
    rd(32'h000);

    // overflow: fifth byte dropped, overrun reported on next read
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    repeat (4) @(negedge clock);
    rd(32'h301);
    rd(32'h102);
    rd(32'h103);
    rd(32'h104);
    rd(32'h000);

    // framing error
    send(8'hA5, 1'b0);
    repeat (4) @(negedge clock);
    rd(32'h400);
    rd(32'h000);

    // glitch: 2-cycle low pulse is rejected at start validation
    uart_rx = 1'b0;
    repeat (2) @(negedge clock);
    uart_rx = 1'b1;
    repeat (20) @(negedge clock);
    rd(32'h000);
    send(8'h3C, 1'b1);
    repeat (4) @(negedge clock);
    rd(32'h13C);

    // full FIFO: read lands on the stop-bit sample cycle of the fifth byte
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1);
    fork
      send(8'h14, 1'b1);
      begin
        repeat (10 * CPB - 2) @(negedge clock);
        rd(32'h110);
      end
    join
    repeat (4) @(negedge clock);
    rd(32'h111);
    rd(32'h112);
    rd(32'h113);
    rd(32'h114);

    // mid-frame reset with a byte already queued
    send(8'h77, 1'b1);
    fork
      send(8'h99, 1'b1);
      begin
        repeat (30) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("midrst_ready", {31'b0, uart_ready}, 32'h0);
        check("midrst_rdata", uart_rdata, 32'h0);
      end
    join
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    rd(32'h000);
    send(8'h42, 1'b1);
    repeat (4) @(negedge clock);
    rd(32'h142);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_port.md
# uart_rx_port

Memory-mapped UART receiver for the SoC peripheral bus, decoded at the uart_rx window (base 0x1000004, mask 0x3). It samples the serial rx pin at the configured baud rate, frames 8N1 characters and pushes them into a small FIFO. The CPU pops one character per bus read. It is the receive-side counterpart of the UART transmitter port and shares its bus handshake and bit-clock divider.

## Interface
- CLKS_PER_BIT, default clk_divider_bit (cpu_freq / baudrate = 173): clock cycles per serial bit; must be ≥ 4.
- DEPTH, default buffer_depth (4): receive FIFO entries; power of two.
- reset  in  1  asynchronous, active-low reset.
- clock  in  1  CPU clock; all logic is on its rising edge.
- uart_valid  in  1  bus request strobe, one cycle per access.
- uart_instr  in  1  instruction fetch flag; ignored.
- uart_addr  in  32  byte address; ignored (the window holds one register).
- uart_wdata  in  32  write data; ignored.
- uart_wstrb  in  4  write strobes; nonzero marks a write, zero marks a read.
- uart_rdata  out  32  read data.
- uart_ready  out  1  response strobe, one cycle.
- uart_rx  in  1  serial input; idle level is high; asynchronous to clock.

## Operation
- **Synchronizer.** uart_rx passes through two flops to give rx_s. The reset value of both flops is 1.
- **State machine:** IDLE, START, DATA, STOP. A cycle counter cnt and a bit index idx (0..7) support it.
- **IDLE.** A falling edge on rx_s (previous 1, current 0) clears cnt and moves the FSM to START.
- **START.** When cnt = CLKS_PER_BIT/2 − 1, the FSM samples rx_s.
  - If rx_s = 0: clear cnt, set idx = 0, move to DATA.
  - If rx_s = 1: treat it as a glitch and return to IDLE. No flag is set.
- **DATA.** When cnt = CLKS_PER_BIT − 1, shift rx_s into shift[idx] (LSB first) and clear cnt. After idx = 7, move to STOP.
- **STOP.** When cnt = CLKS_PER_BIT − 1, sample rx_s.
  - If rx_s = 1 and the FIFO is not full: push shift.
  - If rx_s = 1 and the FIFO is full: drop the byte and set overrun.
  - If rx_s = 0: drop the byte and set ferr.
  - In all three cases the FSM returns to IDLE.
  - A new start bit is accepted on the first falling edge seen in IDLE.
- **Bus writes** (uart_valid with uart_wstrb ≠ 0): no state change; uart_ready pulses.
- **Bus reads:** uart_rdata = {21'b0, ferr, overrun, nonempty, head[7:0]}.
  - If the FIFO is empty, head reads as 0.
  - A read pops the FIFO when it is nonempty.
  - A read clears ferr and overrun. A flag set in the same cycle as the clearing read wins, so it stays 1.
- **Simultaneous pop and push.**
  - Both take effect and the count is unchanged.
  - If the FIFO is full, the pop frees the slot, so the push is accepted and overrun is not set.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- **Reset (async assert, at any time, including mid-frame):**
  - FSM → IDLE, cnt = 0, idx = 0, shift = 0.
  - FIFO emptied.
  - ferr = 0, overrun = 0.
  - uart_ready = 0, uart_rdata = 0.

## Timing
- Synchronizer latency is 2 cycles from a pin change.
- Start-bit validation happens CLKS_PER_BIT/2 cycles after the detected falling edge.
- Each data-bit sample follows the previous one by CLKS_PER_BIT cycles, so samples land at mid-bit.
- A pushed byte is visible (nonempty = 1) in the cycle after the stop-bit sample.
- Bus response latency is fixed at 1 cycle: uart_ready and uart_rdata are registered and valid in the cycle after uart_valid.
  - uart_ready is high for exactly one cycle.
  - Between responses, uart_rdata holds its last value.
- Back-to-back requests on consecutive cycles are each answered one cycle later. The pop is applied at response time.
- Throughput is one character per 10·CLKS_PER_BIT cycles, continuous, with no lost characters while the FIFO has room.

## Test plan
All scenarios use CLKS_PER_BIT = 8 and DEPTH = 4.
- **Single byte.** Drive 0x55 as 8N1 and read once → rdata = 0x155; a second read → 0x000; uart_ready is high 1 cycle after each uart_valid.
- **Overflow.** Send 0x01..0x05 back-to-back with no reads → four reads return 0x101, 0x102, 0x103, 0x104; the first of these also has bit 9 set; a fifth read → 0x000.
- **Framing error.** Send 0xA5 with the stop bit held low → read → 0x400, FIFO empty; the next read → 0x000.
- **Glitch.** Pulse rx low for 2 cycles → no push, no flags, FSM back in IDLE; a following 0x3C is received correctly as 0x13C.
- **Full FIFO, pop and push in the same cycle.** Fill with 0x10..0x13, then issue a read in the same cycle as the stop-bit sample of 0x14 → overrun stays 0; subsequent reads → 0x111, 0x112, 0x113, 0x114.
- **Mid-frame reset.** Assert reset during DATA of 0x99 → outputs zero and FIFO empty; after release, 0x42 is received → 0x142.
